// File: rtl/bitwise_logic_seq_pkg.sv
// Shared opcode and state definitions for the lane-serial bitwise logic unit.
// Imported by the lane datapath and by the top-level controller.
package bitwise_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_XNOR = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A single-beat configuration still needs a one-bit beat counter.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/bitwise_logic_seq_lane_op.sv
// Combinational eight-way bitwise function applied to one LANE_W-bit slice.
// Purely bitwise, so no state or carries cross lane boundaries.
module bitwise_lane_op
  import bitwise_pkg::*;
#(
  parameter int LANE_W = 8
) (
  input  logic [2:0]        op,
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] y
);

  always_comb begin
    y = a;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_NOT:  y = ~a;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/bitwise_logic_seq.sv
// Lane-serial bitwise logic unit: captures two WIDTH-bit operands, processes
// LANE_W bits per clock, and returns result plus parity/zero flags by handshake.
module bitwise_logic_seq
  import bitwise_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int LANE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             parity,
  output logic             zero
);

  // WIDTH is expected to be an exact multiple of LANE_W.
  localparam int BEATS = WIDTH / LANE_W;
  localparam int CNT_W = cnt_width(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_beat;
  logic [2:0]       r_op_q;
  logic [WIDTH-1:0] r_a_q;
  logic [WIDTH-1:0] r_b_q;
  logic [WIDTH-1:0] r_result;
  logic             r_parity_acc;
  logic             r_zero_acc;

  logic [LANE_W-1:0] w_a_slices [BEATS];
  logic [LANE_W-1:0] w_b_slices [BEATS];
  logic [LANE_W-1:0] w_a_lane;
  logic [LANE_W-1:0] w_b_lane;
  logic [LANE_W-1:0] w_y_lane;
  logic [WIDTH-1:0]  w_result_next;
  logic              w_last_beat;

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_lane
      assign w_a_slices[gi] = r_a_q[gi*LANE_W +: LANE_W];
      assign w_b_slices[gi] = r_b_q[gi*LANE_W +: LANE_W];
      // Only the lane addressed by the beat counter takes the new value.
      assign w_result_next[gi*LANE_W +: LANE_W] =
        (r_beat == CNT_W'(gi)) ? w_y_lane : r_result[gi*LANE_W +: LANE_W];
    end
  endgenerate

  always_comb begin
    w_a_lane = '0;
    w_b_lane = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (r_beat == CNT_W'(i)) begin
        w_a_lane = w_a_slices[i];
        w_b_lane = w_b_slices[i];
      end
    end
  end

  assign w_last_beat = (r_beat == LAST_BEAT);

  bitwise_lane_op #(
    .LANE_W (LANE_W)
  ) u_lane_op (
    .op (r_op_q),
    .a  (w_a_lane),
    .b  (w_b_lane),
    .y  (w_y_lane)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_beat       <= '0;
      r_op_q       <= OP_AND;
      r_a_q        <= '0;
      r_b_q        <= '0;
      r_result     <= '0;
      r_parity_acc <= 1'b0;
      r_zero_acc   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_op_q       <= op;
            r_a_q        <= a;
            r_b_q        <= b;
            r_result     <= '0;
            r_parity_acc <= 1'b0;
            r_zero_acc   <= 1'b1;
            r_beat       <= '0;
            r_in_ready   <= 1'b0;
            r_state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_result     <= w_result_next;
          r_parity_acc <= r_parity_acc ^ (^w_y_lane);
          r_zero_acc   <= r_zero_acc & (w_y_lane == '0);
          if (w_last_beat) begin
            r_beat      <= '0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end
        S_DONE: begin
          // No accept here: a new operation waits for the IDLE cycle.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_beat      <= '0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign parity    = r_parity_acc;
  assign zero      = r_zero_acc;

endmodule

// File: tb/tb_bitwise_logic_seq.sv
// Self-checking bench: full-width reference model checked every cycle on the
// 8-bit-lane instance, plus directed literal checks on both lane widths.
module tb_bitwise_logic_seq;

  localparam int WIDTH  = 32;
  localparam int BEATS8 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, parity, zero;
  logic [2:0]  op;
  logic [31:0] a, b, result;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_parity, s_zero;
  logic [2:0]  s_op;
  logic [31:0] s_a, s_b, s_result;

  bitwise_logic_seq #(.WIDTH(WIDTH), .LANE_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .parity(parity), .zero(zero)
  );

  bitwise_logic_seq #(.WIDTH(WIDTH), .LANE_W(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op),
    .a(s_a), .b(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .result(s_result), .parity(s_parity), .zero(s_zero)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~(x ^ y);
      3'd4:    return ~(x & y);
      3'd5:    return ~(x | y);
      3'd6:    return ~x;
      default: return x;
    endcase
  endfunction

  // Reference model: 0 = waiting for work, 1 = computing, 2 = holding result
  int          m_phase = 0;
  int          m_left  = 0;
  logic        m_have  = 1'b0;
  logic [31:0] m_exp   = 32'h0;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("in_ready", 32'(in_ready), 32'(m_phase == 0));
        check("out_valid", 32'(out_valid), 32'(m_phase == 2));
        if (m_phase == 2) begin
          check("result", result, m_exp);
          check("parity", 32'(parity), 32'(^m_exp));
          check("zero", 32'(zero), 32'(m_exp == 32'h0));
        end else if (m_phase == 0) begin
          if (m_have) begin
            check("result_hold", result, m_exp);
          end else begin
            check("idle_result", result, 32'h0);
            check("idle_zero", 32'(zero), 32'h1);
            check("idle_parity", 32'(parity), 32'h0);
          end
        end
        if (rst) begin
          m_phase = 0;
          m_have  = 1'b0;
          m_exp   = 32'h0;
        end else begin
          case (m_phase)
            0: if (in_valid) begin
              m_exp   = ref_op(op, a, b);
              m_phase = 1;
              m_left  = BEATS8;
              $display("txn cycle=%0d op=%0d a=%h b=%h expect=%h", cyc, op, a, b, m_exp);
            end
            1: begin
              m_left--;
              if (m_left == 0) m_phase = 2;
            end
            default: if (out_ready) begin
              m_phase = 0;
              m_have  = 1'b1;
            end
          endcase
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check("idle_seen", 32'(in_ready), 32'h1);
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    check("out_valid_seen", 32'(out_valid), 32'h1);
  endtask

  // One full operation with out_ready high; checks latency and busy window.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input logic ep, input logic ez);
    int n;
    int low_cnt;
    wait_idle();
    in_valid = 1'b1; op = o; a = x; b = y;
    step();
    in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    low_cnt = in_ready ? 0 : 1;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
      if (!in_ready) low_cnt++;
    end
    check("latency", 32'(n), 32'(BEATS8));
    check("lit_result", result, er);
    check("lit_parity", 32'(parity), 32'(ep));
    check("lit_zero", 32'(zero), 32'(ez));
    step();
    if (!in_ready) low_cnt++;
    check("inready_low_cycles", 32'(low_cnt), 32'(BEATS8 + 1));
    check("out_valid_drop", 32'(out_valid), 32'h0);
  endtask

  initial begin
    int n;
    int t1;
    int t2;
    logic prev_ready;

    rst = 1'b1;
    in_valid = 1'b0; op = 3'd0; a = 32'h0; b = 32'h0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_op = 3'd0; s_a = 32'h0; s_b = 32'h0; s_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_zero", 32'(zero), 32'h1);
    check("rst_parity", 32'(parity), 32'h0);
    check("rst32_in_ready", 32'(s_in_ready), 32'h1);
    check("rst32_out_valid", 32'(s_out_valid), 32'h0);
    chk_en = 1'b1;

    run_op(3'd2, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1'b0);
    run_op(3'd2, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b1);
    run_op(3'd0, 32'h00000001, 32'h00000003, 32'h00000001, 1'b1, 1'b0);
    run_op(3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0);

    // Backpressure with stray in_valid pulses while the result is held
    wait_idle();
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd5; a = 32'h0; b = 32'h0;
    step();
    in_valid = 1'b0;
    wait_out_valid(n);
    for (int i = 0; i < 6; i++) begin
      in_valid = (i % 2 == 0);
      op = 3'd0; a = $urandom; b = $urandom;
      check("bp_result", result, 32'hFFFFFFFF);
      check("bp_parity", 32'(parity), 32'h0);
      check("bp_in_ready", 32'(in_ready), 32'h0);
      step();
    end
    check("bp_still_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    in_valid = 1'b1; op = 3'd2; a = 32'h00000001; b = 32'h00000003;
    step();
    check("release_idle", 32'(in_ready), 32'h1);
    check("release_drop", 32'(out_valid), 32'h0);
    step();
    check("release_accept", 32'(in_ready), 32'h0);
    in_valid = 1'b0;
    wait_out_valid(n);
    check("release_result", result, 32'h00000002);
    check("release_parity", 32'(parity), 32'h1);

    // Reset in the middle of an operation
    wait_idle();
    in_valid = 1'b1; op = 3'd1; a = 32'h12345678; b = 32'h0;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'h0);
    check("abort_result", result, 32'h0);
    check("abort_zero", 32'(zero), 32'h1);
    check("abort_in_ready", 32'(in_ready), 32'h1);
    for (int i = 0; i < 8; i++) begin
      step();
      check("abort_no_output", 32'(out_valid), 32'h0);
    end

    // Back-to-back accepts with continuous in_valid
    wait_idle();
    out_ready = 1'b1;
    in_valid = 1'b1; op = 3'd3; a = 32'hA5A5A5A5; b = 32'h0F0F0F0F;
    t1 = -1; t2 = -1;
    prev_ready = in_ready;
    for (int i = 0; i < 40 && t2 < 0; i++) begin
      step();
      if (prev_ready && !in_ready) begin
        if (t1 < 0) begin
          t1 = cyc;
          op = 3'd4; a = 32'hFF00FF00; b = 32'hF0F0F0F0;
        end else begin
          t2 = cyc;
          in_valid = 1'b0;
        end
      end
      prev_ready = in_ready;
    end
    in_valid = 1'b0;
    check("b2b_spacing", 32'(t2 - t1), 32'(BEATS8 + 2));
    wait_out_valid(n);
    check("b2b_result", result, 32'h0FFF0FFF);
    step();
    wait_idle();

    // Single-beat instance
    s_in_valid = 1'b1; s_op = 3'd6; s_a = 32'h0000FFFF; s_b = 32'hAAAAAAAA;
    step();
    s_in_valid = 1'b0; s_a = 32'h0; s_op = 3'd0;
    check("w32_busy_out_valid", 32'(s_out_valid), 32'h0);
    check("w32_busy_in_ready", 32'(s_in_ready), 32'h0);
    step();
    check("w32_out_valid", 32'(s_out_valid), 32'h1);
    check("w32_result", s_result, 32'hFFFF0000);
    check("w32_parity", 32'(s_parity), 32'h0);
    check("w32_zero", 32'(s_zero), 32'h0);
    step();
    check("w32_done_drop", 32'(s_out_valid), 32'h0);
    check("w32_idle", 32'(s_in_ready), 32'h1);

    repeat (3) step();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitwise_logic_seq.md
Name: bitwise_logic_seq

Overview:
- Parametrised, sequential successor to the fixed 32-bit bitwise XOR array.
- Applies one of eight bitwise operations to two WIDTH-bit operands.
- Processes LANE_W bits per clock over WIDTH/LANE_W beats.
- Accumulates a parity flag and a zero flag, and returns the result through valid/ready handshakes on the input and output sides.
- Sits between a register-file/operand source and any consumer that needs wide logic ops without a full-width combinational array.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of LANE_W.
- LANE_W, 8, bits processed per cycle; LANE_W == WIDTH gives single-beat operation.
- BEATS, WIDTH/LANE_W (derived localparam), beats per operation; counter width is $clog2(BEATS), minimum 1.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/opcode valid.
- in_ready  output  1  block can accept a new operation.
- op  input  3  opcode: 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR, 6 NOT a, 7 PASS a.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (ignored for op 6, 7).
- out_valid  output  1  result, parity and zero are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered bitwise result.
- parity  output  1  XOR-reduction of result (1 = odd count of ones).
- zero  output  1  1 when result == 0.

Behaviour:
- One clock (clk); reset rst is synchronous and active-high.
- Reset values (any state, including mid-operation): state=IDLE, in_ready=1, out_valid=0, result=0, parity=0, zero=1, beat counter=0. Any in-flight operation is discarded without output.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. When in_valid && in_ready at an edge: latch a, b and op into internal registers, clear result to 0, parity_acc=0, zero_acc=1, beat=0, go to BUSY.
  - BUSY: in_ready=0, out_valid=0. Each cycle compute f(op, a_q[beat*LANE_W +: LANE_W], b_q[same slice]) and write it into result[same slice]. Update parity_acc ^= ^slice and zero_acc &= (slice == 0). Increment beat. After the beat with beat == BEATS-1, go to DONE.
  - DONE: out_valid=1, in_ready=0. result, parity and zero are held stable. On out_ready at an edge, go to IDLE, out_valid drops next cycle, and result keeps its value until the next accept.
- Latency: accept at edge E0 gives out_valid high after edge E(BEATS). With BEATS=1, out_valid is high the cycle after accept.
- Throughput: at most one operation per BEATS+2 cycles. There is no accept in DONE and no bypass, even if out_ready and in_valid are high together; the new operation is accepted from IDLE on the following edge.
- in_valid in BUSY or DONE is ignored. a, b and op may change freely after accept because they are captured.
- Opcode arithmetic is purely bitwise per lane, with no carries between lanes.
- Unprocessed lanes read 0 while BUSY. result is only meaningful when out_valid=1.
- parity and zero reflect only the completed operation, never partial state while out_valid=1.
- out_ready while not in DONE has no effect.

Decomposition:
- Shared package bitwise_pkg:
  - opcode localparams OP_AND..OP_PASS (3-bit).
  - state encoding S_IDLE, S_BUSY, S_DONE (2-bit).
- One combinational sub-module bitwise_lane_op (parameter LANE_W; ports op, a, b, y) implements the 8-way lane function.
- The top level holds the FSM, beat counter, operand capture registers and flag accumulators.

Test Plan:
- WIDTH=32, LANE_W=8, op=2 (XOR), a=0xFFFF0000, b=0x0F0F0F0F, out_ready=1: out_valid rises exactly 4 cycles after accept, result=0xF0F00F0F, parity=0, zero=0, in_ready low for 5 cycles.
- op=2, a=b=0xDEADBEEF: result=0x00000000, zero=1, parity=0. Then op=0 (AND), a=0x00000001, b=0x00000003: result=0x00000001, parity=1, zero=0.
- Backpressure: op=5 (NOR), a=0, b=0, out_ready held low for 6 cycles after out_valid, with in_valid pulsed with other operands meanwhile: result stays 0xFFFFFFFF, parity=0, new operation not accepted. Release out_ready, then the next operation is accepted one cycle after returning to IDLE.
- Reset mid-operation: accept op=1 (OR), a=0x12345678, b=0; assert rst after 2 BUSY cycles: next cycle out_valid=0, result=0, zero=1, in_ready=1, and no out_valid ever appears for the aborted operation.
- WIDTH=32, LANE_W=32, op=6 (NOT a), a=0x0000FFFF, b=0xAAAAAAAA: out_valid the cycle after accept, result=0xFFFF0000, parity=0, zero=0.
- Back-to-back: two operations with continuous in_valid and out_ready=1: second accept occurs exactly BEATS+2 cycles after the first.
